combination_search_controller: RTL

- Sequences the combinational button-combination XOR datapath to solve one machine's indicator-light problem.
- Walks every press combination of the active buttons and feeds each one to the datapath. Compares the returned light pattern with the target.
- Reports the fewest presses that reach the target, plus the winning combination.
- Sits between the per-machine input loader (start/target/button_count) and the result accumulator (done/found/min_presses).

---
 rtl/combination_search_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/combination_search_controller.sv
// Scans every press combination of up to MAX_BUTTON_COUNT buttons and keeps the lowest-popcount match.
// Optional macro COMB_SEARCH_EARLY_EXIT_EN stops the scan once a popcount <= 1 match is recorded.
module combination_search_controller #(
   parameter int MAX_BUTTON_COUNT = 13,
   parameter int MACHINE_COUNT    = 10,
   parameter int PRESS_W          = $clog2(MAX_BUTTON_COUNT + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [MACHINE_COUNT-1:0]    target,
   input  logic [PRESS_W-1:0]          button_count,
   output logic [MAX_BUTTON_COUNT:0]   combination,
   input  logic [MACHINE_COUNT-1:0]    xor_result,
   output logic                        busy,
   output logic                        done,
   output logic                        found,
   output logic [PRESS_W-1:0]          min_presses,
   output logic [MAX_BUTTON_COUNT-1:0] best_combination
);

   localparam int CW = MAX_BUTTON_COUNT + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [PRESS_W-1:0] N_MAX = PRESS_W'(MAX_BUTTON_COUNT);
   localparam logic [PRESS_W-1:0] P_ONE = {{(PRESS_W-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      C_ONE = {{(CW-1){1'b0}}, 1'b1};

   function automatic logic [PRESS_W-1:0] popcount(input logic [MAX_BUTTON_COUNT-1:0] v);
      logic [PRESS_W-1:0] c;
      c = '0;
      for (int i = 0; i < MAX_BUTTON_COUNT; i++) begin
         c = c + {{(PRESS_W-1){1'b0}}, v[i]};
      end
      return c;
   endfunction

   logic [1:0]                  state_r;
   logic [MACHINE_COUNT-1:0]    target_r;
   logic [PRESS_W-1:0]          n_r;
   logic [CW-1:0]               comb_r;
   logic                        busy_r;
   logic                        done_r;
   logic                        found_r;
   logic [PRESS_W-1:0]          min_r;
   logic [MAX_BUTTON_COUNT-1:0] best_r;

   logic [PRESS_W-1:0]          pc_s;
   logic                        match_s;
   logic                        better_s;
   logic                        last_s;
   logic                        exit_s;
   logic [PRESS_W-1:0]          n_in_s;

   assign combination      = comb_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign found            = found_r;
   assign min_presses      = min_r;
   assign best_combination = best_r;

   // Evaluate the current combination against the latched target and decide whether the scan ends.
   always_comb begin
      pc_s     = popcount(comb_r[MAX_BUTTON_COUNT-1:0]);
      match_s  = (xor_result == target_r);
      better_s = match_s && (!found_r || (pc_s < min_r));
      last_s   = (comb_r == ((C_ONE << n_r) - C_ONE));
`ifdef COMB_SEARCH_EARLY_EXIT_EN
      // Popcount 0 or 1 cannot be beaten by any later (higher-valued) combination.
      exit_s   = last_s || (better_s && (pc_s <= P_ONE));
`else
      exit_s   = last_s;
`endif
      n_in_s   = (button_count > N_MAX) ? N_MAX : button_count;
   end

   // Search sequencer: latch on start, one combination per cycle, single-cycle done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         target_r <= '0;
         n_r      <= '0;
         comb_r   <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         found_r  <= 1'b0;
         min_r    <= '0;
         best_r   <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  target_r <= target;
                  n_r      <= n_in_s;
                  comb_r   <= '0;
                  found_r  <= 1'b0;
                  min_r    <= '0;
                  best_r   <= '0;
                  busy_r   <= 1'b1;
                  state_r  <= ST_SCAN;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (better_s) begin
                  found_r <= 1'b1;
                  min_r   <= pc_s;
                  best_r  <= comb_r[MAX_BUTTON_COUNT-1:0];
               end
               // Stopping at 2^n-1 keeps the overflow bit clear for every evaluated value.
               if (exit_s) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  comb_r  <= comb_r + C_ONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule
